// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signals of the hazard/stall controller: ID/EX hazard inputs in,
// register hold/flush/bubble controls out.
interface hazard_stall_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_dest;
  logic       id_branch_taken;
  logic       mem_busy;
  logic       pc_hold;
  logic       ifid_hold;
  logic       ifid_flush;
  logic       idex_hold;
  logic       idex_bubble;
  logic       exmem_hold;

  // The pipeline drives the hazard inputs and obeys the controls
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read,
           ex_dest, id_branch_taken, mem_busy,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read,
           ex_dest, id_branch_taken, mem_busy,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, branch flush and memory freeze sequencing for the 5-stage MIPS pipe.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_stall_ctrl_if.slave    bus,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      load_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FREEZE     = 2'd2
  } state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  state_t     eff_state;
  logic [2:0] stall_q, stall_d;
  logic       rs_match, rt_match, hazard;

  assign rs_match = bus.id_uses_rs && (bus.id_rs == bus.ex_dest);
  assign rt_match = bus.id_uses_rt && (bus.id_rt == bus.ex_dest);
  assign hazard   = bus.id_valid && bus.ex_mem_read && (bus.ex_dest != 5'd0)
                    && (rs_match || rt_match);

  // A frozen pipe behaves as its saved state once memory is ready again
  always_comb begin
    state_d         = state_q;
    ret_d           = ret_q;
    stall_d         = stall_q;
    bus.pc_hold     = 1'b0;
    bus.ifid_hold   = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_hold   = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.exmem_hold  = 1'b0;
    eff_state       = (state_q == FREEZE) ? ret_q : state_q;

    if (reset) begin
      state_d = RUN;
    end else if (bus.mem_busy) begin
      bus.pc_hold    = 1'b1;
      bus.ifid_hold  = 1'b1;
      bus.idex_hold  = 1'b1;
      bus.exmem_hold = 1'b1;
      state_d        = FREEZE;
      if (state_q != FREEZE) ret_d = state_q;
    end else begin
      case (eff_state)
        LOAD_STALL: begin
          bus.pc_hold     = 1'b1;
          bus.ifid_hold   = 1'b1;
          bus.idex_bubble = 1'b1;
          stall_d         = stall_q - 3'd1;
          state_d         = (stall_q == 3'd1) ? RUN : LOAD_STALL;
        end
        default: begin
          state_d = RUN;
          if (hazard) begin
            bus.pc_hold     = 1'b1;
            bus.ifid_hold   = 1'b1;
            bus.idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              stall_d = STALL_RELOAD;
            end
          end else if (bus.id_branch_taken) begin
            bus.ifid_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      stall_q <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      freeze_cnt     <= '0;
    end else begin
      if (bus.idex_bubble && !(&load_stall_cnt)) load_stall_cnt <= load_stall_cnt + CNT_W'(1);
      if (bus.ifid_flush && !(&flush_cnt))       flush_cnt      <= flush_cnt + CNT_W'(1);
      if (bus.mem_busy && !(&freeze_cnt))        freeze_cnt     <= freeze_cnt + CNT_W'(1);
    end
  end
`else
  assign load_stall_cnt = '0;
  assign flush_cnt      = '0;
  assign freeze_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (1- and 3-cycle load stalls) share one
// stimulus stream and are compared every cycle against a stall-debt reference model.
module tb_hazard_stall_ctrl;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mrd;
    logic [4:0] dest;
    logic       br;
    logic       busy;
  } stim_t;

  logic             clk = 1'b0;
  logic             reset;
  stim_t            cur;
  logic [1:0]       state1, state3;
  logic [CNT_W-1:0] lc1, fc1, zc1, lc3, fc3, zc3;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus1 ();
  hazard_stall_ctrl_if bus3 ();

  assign bus1.id_valid = cur.valid;        assign bus3.id_valid = cur.valid;
  assign bus1.id_rs = cur.rs;              assign bus3.id_rs = cur.rs;
  assign bus1.id_rt = cur.rt;              assign bus3.id_rt = cur.rt;
  assign bus1.id_uses_rs = cur.urs;        assign bus3.id_uses_rs = cur.urs;
  assign bus1.id_uses_rt = cur.urt;        assign bus3.id_uses_rt = cur.urt;
  assign bus1.ex_mem_read = cur.mrd;       assign bus3.ex_mem_read = cur.mrd;
  assign bus1.ex_dest = cur.dest;          assign bus3.ex_dest = cur.dest;
  assign bus1.id_branch_taken = cur.br;    assign bus3.id_branch_taken = cur.br;
  assign bus1.mem_busy = cur.busy;         assign bus3.mem_busy = cur.busy;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .state(state1),
    .load_stall_cnt(lc1), .flush_cnt(fc1), .freeze_cnt(zc1)
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .state(state3),
    .load_stall_cnt(lc3), .flush_cnt(fc3), .freeze_cnt(zc3)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: bubbles still owed, whether last cycle was frozen, and event tallies
  int lsc [2] = '{1, 3};
  int m_rem [2];
  bit m_prev_busy [2];
  int m_lcnt [2];
  int m_fcnt [2];
  int m_zcnt [2];

  bit                   exp_hz;
  bit                   exp_bb [2];
  bit                   exp_fl [2];
  logic [7:0]           exp_o  [2];
  logic [3*CNT_W-1:0]   exp_c  [2];

  function automatic stim_t mk(input logic rst, input logic valid, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs, input logic urt,
                               input logic mrd, input logic [4:0] dest, input logic br,
                               input logic busy);
    stim_t s;
    s = '{rst, valid, rs, rt, urs, urt, mrd, dest, br, busy};
    return s;
  endfunction

  function automatic logic [15:0] act_o();
    return {bus1.pc_hold, bus1.ifid_hold, bus1.ifid_flush, bus1.idex_hold,
            bus1.idex_bubble, bus1.exmem_hold, state1,
            bus3.pc_hold, bus3.ifid_hold, bus3.ifid_flush, bus3.idex_hold,
            bus3.idex_bubble, bus3.exmem_hold, state3};
  endfunction

  function automatic logic [6*CNT_W-1:0] act_c();
    return {lc1, fc1, zc1, lc3, fc3, zc3};
  endfunction

  task automatic model_eval();
    bit ph, ih, fl, eh, bb, xh;
    logic [1:0] st;
    exp_hz = cur.valid && cur.mrd && (cur.dest != 0) &&
             ((cur.urs && cur.rs == cur.dest) || (cur.urt && cur.rt == cur.dest));
    for (int k = 0; k < 2; k++) begin
      {ph, ih, fl, eh, bb, xh} = '0;
      st = m_prev_busy[k] ? 2'd2 : ((m_rem[k] > 0) ? 2'd1 : 2'd0);
      if (!cur.rst) begin
        if (cur.busy) {ph, ih, eh, xh} = 4'b1111;
        else if (m_rem[k] > 0 || exp_hz) {ph, ih, bb} = 3'b111;
        else if (cur.br) fl = 1'b1;
      end
      exp_bb[k] = bb;
      exp_fl[k] = fl;
      exp_o[k]  = {ph, ih, fl, eh, bb, xh, st};
`ifdef HAZARD_PERF_CNT_EN
      exp_c[k] = {CNT_W'(m_lcnt[k]), CNT_W'(m_fcnt[k]), CNT_W'(m_zcnt[k])};
`else
      exp_c[k] = '0;
`endif
    end
  endtask

  task automatic drive_row(input stim_t s);
    cur   = s;
    reset = s.rst;
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (cur.rst) begin
        m_rem[k] = 0; m_prev_busy[k] = 0;
        m_lcnt[k] = 0; m_fcnt[k] = 0; m_zcnt[k] = 0;
      end else begin
        if (cur.busy) begin
          m_prev_busy[k] = 1;
          if (m_zcnt[k] < CNT_MAX) m_zcnt[k]++;
        end else begin
          m_prev_busy[k] = 0;
          if (m_rem[k] > 0) m_rem[k]--;
          else if (exp_hz) m_rem[k] = lsc[k] - 1;
        end
        if (exp_bb[k] && m_lcnt[k] < CNT_MAX) m_lcnt[k]++;
        if (exp_fl[k] && m_fcnt[k] < CNT_MAX) m_fcnt[k]++;
      end
    end
    cyc++;
    #1;
  endtask

  stim_t IDLE, HAZ, HAZ_BR, BR, BUSY, RST;

  task automatic test_reset();
    stim_t rows [$];
    rows = '{RST, IDLE, IDLE};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      checks++;
      if (act_o() !== {exp_o[0], exp_o[1]}) begin
        errors++;
        $display("[TB] FAIL reset_outputs cyc %0d: got %h expected %h", cyc, act_o(), {exp_o[0], exp_o[1]});
      end
      checks++;
      if (act_c() !== {exp_c[0], exp_c[1]}) begin
        errors++;
        $display("[TB] FAIL reset_counters cyc %0d: got %h expected %h", cyc, act_c(), {exp_c[0], exp_c[1]});
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    stim_t rows [$];
    rows = '{IDLE, HAZ, IDLE, IDLE, IDLE,
             mk(0, 1, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0),
             mk(0, 1, 5'd0, 5'd9, 1, 1, 1, 5'd0, 0, 0),
             mk(0, 1, 5'd7, 5'd2, 0, 1, 1, 5'd7, 0, 0),
             mk(0, 1, 5'd7, 5'd2, 1, 0, 1, 5'd7, 0, 0),
             IDLE, IDLE, IDLE,
             mk(0, 0, 5'd7, 5'd7, 1, 1, 1, 5'd7, 0, 0),
             IDLE};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      checks++;
      if (act_o() !== {exp_o[0], exp_o[1]}) begin
        errors++;
        $display("[TB] FAIL load_use_outputs cyc %0d: got %h expected %h", cyc, act_o(), {exp_o[0], exp_o[1]});
      end
      checks++;
      if (act_c() !== {exp_c[0], exp_c[1]}) begin
        errors++;
        $display("[TB] FAIL load_use_counters cyc %0d: got %h expected %h", cyc, act_c(), {exp_c[0], exp_c[1]});
      end
      advance();
    end
  endtask

  task automatic test_branch_hazard();
    stim_t rows [$];
    rows = '{HAZ_BR, BR, BR, BR, IDLE, BR, IDLE};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      checks++;
      if (act_o() !== {exp_o[0], exp_o[1]}) begin
        errors++;
        $display("[TB] FAIL branch_outputs cyc %0d: got %h expected %h", cyc, act_o(), {exp_o[0], exp_o[1]});
      end
      checks++;
      if (act_c() !== {exp_c[0], exp_c[1]}) begin
        errors++;
        $display("[TB] FAIL branch_counters cyc %0d: got %h expected %h", cyc, act_c(), {exp_c[0], exp_c[1]});
      end
      advance();
    end
  endtask

  task automatic test_freeze_stall();
    stim_t rows [$];
    rows = '{IDLE, HAZ, IDLE, BUSY, BUSY, BUSY, BUSY, IDLE, IDLE, IDLE,
             BUSY, HAZ, IDLE, IDLE, IDLE, BR, BUSY, BR, IDLE};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      checks++;
      if (act_o() !== {exp_o[0], exp_o[1]}) begin
        errors++;
        $display("[TB] FAIL freeze_outputs cyc %0d: got %h expected %h", cyc, act_o(), {exp_o[0], exp_o[1]});
      end
      checks++;
      if (act_c() !== {exp_c[0], exp_c[1]}) begin
        errors++;
        $display("[TB] FAIL freeze_counters cyc %0d: got %h expected %h", cyc, act_c(), {exp_c[0], exp_c[1]});
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t rows [$];
    rows = '{HAZ, RST, IDLE, IDLE, HAZ, BUSY, RST, IDLE, IDLE};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      checks++;
      if (act_o() !== {exp_o[0], exp_o[1]}) begin
        errors++;
        $display("[TB] FAIL reset_mid_outputs cyc %0d: got %h expected %h", cyc, act_o(), {exp_o[0], exp_o[1]});
      end
      checks++;
      if (act_c() !== {exp_c[0], exp_c[1]}) begin
        errors++;
        $display("[TB] FAIL reset_mid_counters cyc %0d: got %h expected %h", cyc, act_c(), {exp_c[0], exp_c[1]});
      end
      advance();
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s = mk(($urandom_range(0, 99) < 2), 1'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15));
      drive_row(s);
      checks++;
      if (act_o() !== {exp_o[0], exp_o[1]}) begin
        errors++;
        $display("[TB] FAIL random_outputs cyc %0d: got %h expected %h", cyc, act_o(), {exp_o[0], exp_o[1]});
      end
      checks++;
      if (act_c() !== {exp_c[0], exp_c[1]}) begin
        errors++;
        $display("[TB] FAIL random_counters cyc %0d: got %h expected %h", cyc, act_c(), {exp_c[0], exp_c[1]});
      end
      advance();
    end
  endtask

  initial begin
    IDLE   = mk(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    HAZ    = mk(0, 1, 5'd3, 5'd8, 0, 1, 1, 5'd8, 0, 0);
    HAZ_BR = mk(0, 1, 5'd3, 5'd8, 0, 1, 1, 5'd8, 1, 0);
    BR     = mk(0, 1, 5'd3, 5'd8, 0, 1, 0, 5'd0, 1, 0);
    BUSY   = mk(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1);
    RST    = mk(1, 1, 5'd3, 5'd8, 0, 1, 1, 5'd8, 1, 1);
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_prev_busy[k] = 0;
      m_lcnt[k] = 0; m_fcnt[k] = 0; m_zcnt[k] = 0;
    end
    // Power-up cycle: registers are unknown until the first reset edge
    drive_row(RST);
    advance();

    test_reset();
    test_load_use();
    test_branch_hazard();
    test_freeze_stall();
    test_reset_mid_stall();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
